// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache and D-cache misses onto one multi-cycle main memory and
// streams a full 16-byte block back into the granted cache.
module cache_fill_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_BLK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_miss,
    input  logic [ADDR_W-1:0] I_miss_addr,
    input  logic              D_miss,
    input  logic [ADDR_W-1:0] D_miss_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data_in,
    output logic [15:0]       fill_data,
    output logic [2:0]        fill_word,
    output logic              I_data_we,
    output logic              D_data_we,
    output logic              I_tag_we,
    output logic              D_tag_we,
    output logic              I_fill_done,
    output logic              D_fill_done,
    output logic              busy
);

    localparam int                CNT_W     = 4;
    localparam logic [CNT_W-1:0]  NUM_WORDS = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

    state_t            state;
    grant_t            grant;
    logic [ADDR_W-5:0] blk;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;

    logic rx_fire;
    logic rx_last;

    // Byte offsets inside the block are irrelevant: the whole block is refilled.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{I_miss_addr[3:0], D_miss_addr[3:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= GNT_NONE;
            blk       <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                    if (D_miss) begin
                        grant <= GNT_D;
                        blk   <= D_miss_addr[ADDR_W-1:4];
                        state <= FILL;
                    end else if (I_miss) begin
                        grant <= GNT_I;
                        blk   <= I_miss_addr[ADDR_W-1:4];
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (mem_en) begin
                        issue_cnt <= issue_cnt + CNT_W'(1);
                    end
                    if (rx_fire) begin
                        recv_cnt <= recv_cnt + CNT_W'(1);
                        if (rx_last) begin
                            grant <= GNT_NONE;
                            state <= DONE;
                        end
                    end
                end
                // The tag write lands during this cycle, so the served miss
                // line is already low when IDLE arbitrates again.
                DONE: begin
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en   = (state == FILL) && (issue_cnt < NUM_WORDS);
    assign mem_addr = mem_en ? {blk, issue_cnt[2:0], 1'b0} : '0;

    // Returned words arrive in issue order, so recv_cnt is the word index.
    assign rx_fire   = (state == FILL) && mem_data_valid;
    assign rx_last   = rx_fire && (recv_cnt == LAST_WORD);
    assign fill_data = rx_fire ? mem_data_in : '0;
    assign fill_word = rx_fire ? recv_cnt[2:0] : '0;
    assign busy      = (state != IDLE);

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value held, which would infer a latch.
    always_comb begin
        I_data_we   = 1'b0;
        D_data_we   = 1'b0;
        I_tag_we    = 1'b0;
        D_tag_we    = 1'b0;
        I_fill_done = 1'b0;
        D_fill_done = 1'b0;
        case (grant)
            GNT_I: begin
                I_data_we   = rx_fire;
                I_tag_we    = rx_last;
                I_fill_done = rx_last;
            end
            GNT_D: begin
                D_data_we   = rx_fire;
                D_tag_we    = rx_last;
                D_fill_done = rx_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: a table of expected cycles for the
// basic I fill plus sequences for priority, early drop, reset and latency.
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        I_miss, D_miss;
    logic [15:0] I_miss_addr, D_miss_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        I_data_we, D_data_we, I_tag_we, D_tag_we, I_fill_done, D_fill_done;
    logic        busy;

    int n_checks = 0;
    int n_bad    = 0;
    int lat      = 4;

    // Memory model: a read issued in cycle t returns in cycle t+lat.
    bit          dl_v [8];
    bit   [15:0] dl_a [8];
    logic        man_valid = 1'b0;
    logic [15:0] man_data  = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 7; i++) begin
            dl_v[i] <= dl_v[i+1];
            dl_a[i] <= dl_a[i+1];
        end
        dl_v[7] <= 1'b0;
        dl_v[lat-1] <= mem_en;
        dl_a[lat-1] <= mem_addr;
    end

    assign mem_data_valid = dl_v[0] | man_valid;
    assign mem_data_in    = man_valid ? man_data : (dl_a[0] ^ 16'h5A5A);

    cache_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .I_miss(I_miss), .I_miss_addr(I_miss_addr),
        .D_miss(D_miss), .D_miss_addr(D_miss_addr),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
        .fill_data(fill_data), .fill_word(fill_word),
        .I_data_we(I_data_we), .D_data_we(D_data_we),
        .I_tag_we(I_tag_we), .D_tag_we(D_tag_we),
        .I_fill_done(I_fill_done), .D_fill_done(D_fill_done),
        .busy(busy)
    );

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic        we;
        logic [2:0]  fw;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {5'd0, mem_en, mem_addr, I_data_we, D_data_we, I_tag_we, D_tag_we,
                I_fill_done, D_fill_done, fill_word, busy};
    endfunction

    function automatic logic [31:0] expv(logic en, logic [15:0] addr, logic iwe, logic dwe,
                                         logic itag, logic dtag, logic [2:0] fw, logic bsy);
        return {5'd0, en, addr, iwe, dwe, itag, dtag, itag, dtag, fw, bsy};
    endfunction

    // Checks one fill against the documented timeline; cycle 0 is the IDLE
    // cycle in which the grant is decided.
    task automatic run_fill(input string name, input bit is_d, input logic [15:0] base,
                            input int l, input int ncyc, input int drop_cyc, input bit rel);
        lat = l;
        for (int c = 0; c < ncyc; c++) begin
            logic        en, we, last, bsy;
            logic [15:0] addr;
            logic [2:0]  fw;
            @(negedge clk);
            en   = (c >= 1) && (c <= 8);
            addr = en ? base + 16'(2 * (c - 1)) : 16'h0;
            we   = (c >= 1 + l) && (c <= 8 + l);
            fw   = we ? 3'(c - 1 - l) : 3'd0;
            last = (c == 8 + l);
            bsy  = (c >= 1) && (c <= 9 + l);
            check($sformatf("%s c%0d", name, c), obs(),
                  expv(en, addr, we & ~is_d, we & is_d, last & ~is_d, last & is_d, fw, bsy));
            if (we)
                check($sformatf("%s data c%0d", name, c), {16'd0, fill_data},
                      {16'd0, (base + {12'd0, fw, 1'b0}) ^ 16'h5A5A});
            @(posedge clk);
            #1;
            if (c + 1 == drop_cyc) begin
                if (is_d) begin D_miss = 1'b0; D_miss_addr = 16'h1111; end
                else      begin I_miss = 1'b0; I_miss_addr = 16'h1111; end
            end
            if (rel && c == 8 + l) begin
                if (is_d) D_miss = 1'b0; else I_miss = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{0, 16'h0000, 0, 3'd0, 0, 0};
        vecs[1]  = '{1, 16'h1230, 0, 3'd0, 0, 1};
        vecs[2]  = '{1, 16'h1232, 0, 3'd0, 0, 1};
        vecs[3]  = '{1, 16'h1234, 0, 3'd0, 0, 1};
        vecs[4]  = '{1, 16'h1236, 0, 3'd0, 0, 1};
        vecs[5]  = '{1, 16'h1238, 1, 3'd0, 0, 1};
        vecs[6]  = '{1, 16'h123A, 1, 3'd1, 0, 1};
        vecs[7]  = '{1, 16'h123C, 1, 3'd2, 0, 1};
        vecs[8]  = '{1, 16'h123E, 1, 3'd3, 0, 1};
        vecs[9]  = '{0, 16'h0000, 1, 3'd4, 0, 1};
        vecs[10] = '{0, 16'h0000, 1, 3'd5, 0, 1};
        vecs[11] = '{0, 16'h0000, 1, 3'd6, 0, 1};
        vecs[12] = '{0, 16'h0000, 1, 3'd7, 1, 1};
        vecs[13] = '{0, 16'h0000, 0, 3'd0, 0, 1};
        vecs[14] = '{0, 16'h0000, 0, 3'd0, 0, 0};

        rst_n = 1'b0;
        I_miss = 1'b0; D_miss = 1'b0;
        I_miss_addr = '0; D_miss_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outputs", obs(), 32'd0);
        check("reset fill_data", {16'd0, fill_data}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic I fill from the table.
        I_miss = 1'b1; I_miss_addr = 16'h1236;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check($sformatf("tbl c%0d", c), obs(),
                  expv(vecs[c].en, vecs[c].addr, vecs[c].we, 1'b0, vecs[c].done, 1'b0,
                       vecs[c].fw, vecs[c].busy));
            if (vecs[c].we)
                check($sformatf("tbl data c%0d", c), {16'd0, fill_data},
                      {16'd0, (16'h1230 + {12'd0, vecs[c].fw, 1'b0}) ^ 16'h5A5A});
            @(posedge clk); #1;
            if (c == 12) I_miss = 1'b0;
        end

        // Simultaneous misses: D wins, I follows in the first IDLE after DONE.
        I_miss = 1'b1; I_miss_addr = 16'h0040;
        D_miss = 1'b1; D_miss_addr = 16'h8008;
        run_fill("prio D", 1'b1, 16'h8000, 4, 14, -1, 1'b1);
        run_fill("prio I", 1'b0, 16'h0040, 4, 15, -1, 1'b1);

        // D miss dropped (and address changed) mid-fill: fill still completes.
        D_miss = 1'b1; D_miss_addr = 16'hABCD;
        run_fill("drop D", 1'b1, 16'hABC0, 4, 15, 3, 1'b0);

        // Reset in cycle 6 of a fill, then late and manual valids in IDLE.
        I_miss = 1'b1; I_miss_addr = 16'h2000;
        run_fill("pre-rst", 1'b0, 16'h2000, 4, 6, -1, 1'b0);
        rst_n = 1'b0; I_miss = 1'b0;
        for (int k = 6; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("rst c%0d", k), obs(), 32'd0);
            @(posedge clk); #1;
            if (k == 7) rst_n = 1'b1;
            man_valid = (k == 9 || k == 10);
            man_data  = 16'hBEEF;
        end
        D_miss = 1'b1; D_miss_addr = 16'h4444;
        run_fill("post-rst D", 1'b1, 16'h4440, 4, 15, -1, 1'b1);

        // I miss held continuously across varying memory latencies.
        I_miss = 1'b1; I_miss_addr = 16'h7A5E;
        run_fill("lat2", 1'b0, 16'h7A50, 2, 12, -1, 1'b0);
        run_fill("lat7", 1'b0, 16'h7A50, 7, 17, -1, 1'b0);
        run_fill("lat4", 1'b0, 16'h7A50, 4, 15, -1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
